// File: rtl/int_img_stream.sv
// Streaming integral-image engine: one raster-order pixel in, one integral value out a cycle later.
// Optional squared-integral channel is built only when INT_IMG_SQ_EN is defined; otherwise ii_sq_o is 0.
module int_img_stream #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int PIX_W  = 8,
    parameter int SUM_W  = 32,
    parameter int SQ_W   = 48
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             restart_i,
    input  logic [PIX_W-1:0] pix_in_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    output logic [SUM_W-1:0] ii_data_o,
    output logic [SQ_W-1:0]  ii_sq_o,
    output logic [15:0]      ii_row_o,
    output logic [15:0]      ii_col_o,
    output logic             ii_last_o,
    output logic             ii_valid_o,
    input  logic             ii_ready_i
);

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [15:0]      col_q, col_d, row_q, row_d;
    logic [SUM_W-1:0] rs_q, rs_d, lb_rd, ii_d;
    logic [SUM_W-1:0] lb [WIDTH];
    logic [AW-1:0]    lb_addr;
    logic             accept, first_col, first_row, col_wrap, row_wrap;

    logic [SUM_W-1:0] data_q;
    logic [15:0]      row_out_q, col_out_q;
    logic             last_q, valid_q;

    // Single output register, no skid: a new pixel only enters when the slot is free or draining.
    assign pix_ready_o = !restart_i && (!valid_q || ii_ready_i);
    assign accept      = pix_valid_i && pix_ready_o;

    assign first_col = (col_q == 16'd0);
    assign first_row = (row_q == 16'd0);
    assign col_wrap  = (col_q == 16'(WIDTH - 1));
    assign row_wrap  = (row_q == 16'(HEIGHT - 1));

    assign lb_addr = col_q[AW-1:0];
    assign lb_rd   = lb[lb_addr];

    // Row 0 never looks at the line buffer, so stale contents from a previous frame are harmless.
    assign rs_d = (first_col ? '0 : rs_q) + SUM_W'(pix_in_i);
    assign ii_d = rs_d + (first_row ? '0 : lb_rd);

    assign col_d = col_wrap ? 16'd0 : col_q + 16'd1;
    assign row_d = col_wrap ? (row_wrap ? 16'd0 : row_q + 16'd1) : row_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q     <= '0;
            row_q     <= '0;
            rs_q      <= '0;
            data_q    <= '0;
            row_out_q <= '0;
            col_out_q <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else if (restart_i) begin
            col_q   <= '0;
            row_q   <= '0;
            rs_q    <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            col_q     <= col_d;
            row_q     <= row_d;
            rs_q      <= rs_d;
            data_q    <= ii_d;
            row_out_q <= row_q;
            col_out_q <= col_q;
            last_q    <= col_wrap && row_wrap;
            valid_q   <= 1'b1;
        end else if (ii_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb[lb_addr] <= ii_d;
        end
    end

`ifdef INT_IMG_SQ_EN
    logic [SQ_W-1:0] sq_lb [WIDTH];
    logic [SQ_W-1:0] pix_sq, rs_sq_q, rs_sq_d, sq_rd, sq_d, sq_q;

    assign pix_sq  = SQ_W'(pix_in_i) * SQ_W'(pix_in_i);
    assign sq_rd   = sq_lb[lb_addr];
    assign rs_sq_d = (first_col ? '0 : rs_sq_q) + pix_sq;
    assign sq_d    = rs_sq_d + (first_row ? '0 : sq_rd);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rs_sq_q <= '0;
            sq_q    <= '0;
        end else if (restart_i) begin
            rs_sq_q <= '0;
        end else if (accept) begin
            rs_sq_q <= rs_sq_d;
            sq_q    <= sq_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            sq_lb[lb_addr] <= sq_d;
        end
    end

    assign ii_sq_o = sq_q;
`else
    assign ii_sq_o = '0;
`endif

    assign ii_data_o  = data_q;
    assign ii_row_o   = row_out_q;
    assign ii_col_o   = col_out_q;
    assign ii_last_o  = last_q;
    assign ii_valid_o = valid_q;

endmodule

// File: tb/tb_int_img_stream.sv
// Scoreboard bench for int_img_stream on a 4x3 frame with an 8-bit sum so wraparound is exercised.
module tb_int_img_stream;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int SW = 8;
    localparam int QW = 48;

    logic          clk;
    logic          rst_n;
    logic          restart;
    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [SW-1:0] ii_data;
    logic [QW-1:0] ii_sq;
    logic [15:0]   ii_row;
    logic [15:0]   ii_col;
    logic          ii_last;
    logic          ii_valid;
    logic          ii_ready;

    int_img_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .SUM_W(SW), .SQ_W(QW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .restart_i  (restart),
        .pix_in_i   (pix_in),
        .pix_valid_i(pix_valid),
        .pix_ready_o(pix_ready),
        .ii_data_o  (ii_data),
        .ii_sq_o    (ii_sq),
        .ii_row_o   (ii_row),
        .ii_col_o   (ii_col),
        .ii_last_o  (ii_last),
        .ii_valid_o (ii_valid),
        .ii_ready_i (ii_ready)
    );

    typedef struct packed {
        logic [SW-1:0] data;
        logic [QW-1:0] sq;
        logic [15:0]   row;
        logic [15:0]   col;
        logic          last;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  img[H][W];
    bit  stall_mode = 0;

    // Integral of pixels 1..12 laid out row by row, worked by hand.
    int ramp_exp[12] = '{1, 3, 6, 10, 6, 14, 24, 36, 15, 33, 54, 78};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic sb_t mk(input int r, input int c, input int d);
        sb_t e;
        logic [QW-1:0] s;
        s = '0;
`ifdef INT_IMG_SQ_EN
        for (int i = 0; i <= r; i++)
            for (int j = 0; j <= c; j++)
                s = s + QW'(img[i][j] * img[i][j]);
`endif
        e.data = SW'(d);
        e.sq   = s;
        e.row  = 16'(r);
        e.col  = 16'(c);
        e.last = (r == H - 1) && (c == W - 1);
        return e;
    endfunction

    task automatic send(input int r, input int c, input int p, input int d);
        bit acc;
        int guard;
        acc   = 0;
        guard = 0;
        img[r][c] = p;
        pix_in    = 8'(p);
        pix_valid = 1'b1;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL accept_timeout r=%0d c=%0d pix_ready stuck at %0b, required 1", r, c, pix_ready);
        end else begin
            sb_q.push_back(mk(r, c, d));
            n_vec++;
            if (!(ii_valid && ii_row == 16'(r) && ii_col == 16'(c))) begin
                n_err++;
                $display("FAIL latency r=%0d c=%0d got valid=%0b row=%0d col=%0d, required valid=1 row=%0d col=%0d",
                         r, c, ii_valid, ii_row, ii_col, r, c);
            end
        end
    endtask

    task automatic send_uniform(input int p);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(r, c, p, (p * (r + 1) * (c + 1)) % 256);
    endtask

    task automatic send_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(r, c, r * W + c + 1, ramp_exp[r * W + c]);
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        pix_valid = 1'b0;
        while ((sb_q.size() != 0 || ii_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_vec++;
        if (guard >= 200) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d ii_valid=%0b, required 0 and 0", sb_q.size(), ii_valid);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        n_vec++;
        if (ii_valid !== 1'b0 || ii_data !== '0 || ii_sq !== '0 || ii_row !== 16'd0 ||
            ii_col !== 16'd0 || ii_last !== 1'b0) begin
            n_err++;
            $display("FAIL %s got valid=%0b data=%0d sq=%0d row=%0d col=%0d last=%0b, required all 0",
                     tag, ii_valid, ii_data, ii_sq, ii_row, ii_col, ii_last);
        end
    endtask

    // Downstream ready: either always 1 or the repeating 1,0,0,1 pattern.
    initial begin
        int pidx;
        bit pat[4];
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        pidx = 0;
        ii_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                ii_ready = pat[pidx];
                pidx = (pidx + 1) % 4;
            end else begin
                ii_ready = 1'b1;
            end
        end
    end

    // Monitor: pops on every completed output handshake and checks stability while stalled.
    initial begin
        bit  stalled_prev;
        sb_t snap;
        sb_t got;
        sb_t e;
        stalled_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled_prev = 0;
            end else begin
                got = '{data: ii_data, sq: ii_sq, row: ii_row, col: ii_col, last: ii_last};
                if (stalled_prev) begin
                    n_vec++;
                    if (!ii_valid || got != snap) begin
                        n_err++;
                        $display("FAIL hold got valid=%0b row=%0d col=%0d data=%0d, required valid=1 row=%0d col=%0d data=%0d",
                                 ii_valid, ii_row, ii_col, ii_data, snap.row, snap.col, snap.data);
                    end
                end
                stalled_prev = ii_valid && !ii_ready;
                snap = got;
                if (ii_valid && ii_ready) begin
                    n_vec++;
                    if (sb_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_output row=%0d col=%0d data=%0d, required no output", ii_row, ii_col, ii_data);
                    end else begin
                        e = sb_q.pop_front();
                        $display("out r=%0d c=%0d data=%0d sq=%0d last=%0b", ii_row, ii_col, ii_data, ii_sq, ii_last);
                        if (got != e) begin
                            n_err++;
                            $display("FAIL output got r=%0d c=%0d data=%0d sq=%0d last=%0b, required r=%0d c=%0d data=%0d sq=%0d last=%0b",
                                     ii_row, ii_col, ii_data, ii_sq, ii_last, e.row, e.col, e.data, e.sq, e.last);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        restart   = 1'b0;
        pix_in    = 8'd0;
        pix_valid = 1'b0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_values");
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (pix_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset got %0b, required 1", pix_ready);
        end

        // Unit frame, then the same frame under 1,0,0,1 backpressure.
        send_uniform(1);
        drain();
        stall_mode = 1;
        send_uniform(1);
        drain();
        stall_mode = 0;

        // Saturating pixels wrap mod 256, followed back-to-back by a non-uniform frame.
        send_uniform(255);
        send_ramp();
        drain();

        send_uniform(3);
        drain();

        // Restart after five accepts; the pixel offered alongside restart must be refused.
        for (int k = 0; k < 5; k++)
            send(k / W, k % W, 1, ((k / W) + 1) * ((k % W) + 1));
        pix_in    = 8'd99;
        pix_valid = 1'b1;
        restart   = 1'b1;
        @(negedge clk);
        n_vec++;
        if (pix_ready !== 1'b0) begin
            n_err++;
            $display("FAIL restart_ready got %0b, required 0", pix_ready);
        end
        @(posedge clk);
        #1;
        restart   = 1'b0;
        pix_valid = 1'b0;
        n_vec++;
        if (ii_valid !== 1'b0) begin
            n_err++;
            $display("FAIL restart_discard ii_valid got %0b, required 0", ii_valid);
        end
        send(0, 0, 7, 7);
        send(0, 1, 1, 8);

        // Asynchronous reset mid-frame for one cycle.
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        sb_q.delete();
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (pix_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_midreset got %0b, required 1", pix_ready);
        end
        send_uniform(2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
